// File: rtl/prio_enc_pkg.sv
// Shared definitions for the prio_enc_rr slice: the width limit and the
// index-width helper.
package prio_enc_pkg;

  // Upper bound on the request-vector width.
  localparam int PRIO_N_MAX = 64;

  // Index width for an N-wide request vector. N=1 still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational highest-set-bit finder: binary index, one-hot winner, and an
// all-zero flag. When none=1, idx and onehot are both zero.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         none
);

  // Scan upward so that the highest set bit is the last one written.
  always_comb begin
    idx    = '0;
    onehot = '0;
    none   = ~|req;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx       = W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshakes on the
// input and output sides.
// Optional round-robin mode: define PRIO_ENC_RR_EN. In that mode a pointer
// sets where the downward search starts, and the search wraps around. With
// the macro undefined, the highest set index always wins. That matches
// round-robin mode with the pointer held at N-1.
module prio_enc_rr
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_w(N)   // derived from N; do not override
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_none
);

  logic         accept;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;
  logic         win_none;

  // The output register is a single entry. Draining it and refilling it in
  // the same cycle keeps throughput at one result per cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] ptr;
  logic [N-1:0] lo_mask;
  logic [W-1:0] m_idx,    f_idx;
  logic [N-1:0] m_onehot, f_onehot;
  logic         m_none,   f_none;

  // Bits at or below ptr are searched first, in the order ptr..0.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++)
      lo_mask[i] = (W'(i) <= ptr);
  end

  prio_find #(.N(N), .W(W)) u_find_lo (
    .req    (req & lo_mask),
    .idx    (m_idx),
    .onehot (m_onehot),
    .none   (m_none)
  );

  // If nothing is set at or below ptr, wrap: the highest bit above ptr wins.
  // That bit is also the highest set bit of the unmasked vector.
  prio_find #(.N(N), .W(W)) u_find_all (
    .req    (req),
    .idx    (f_idx),
    .onehot (f_onehot),
    .none   (f_none)
  );

  // Select the masked winner when there is one; otherwise take the fallback.
  always_comb begin
    win_idx    = m_none ? f_idx    : m_idx;
    win_onehot = m_none ? f_onehot : m_onehot;
    win_none   = f_none;
  end

  // After a non-empty grant, move the search start to just below the winner.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= W'(N - 1);
    else if (accept && !win_none)
      ptr <= (win_idx == '0) ? W'(N - 1) : win_idx - W'(1);
  end
`else
  prio_find #(.N(N), .W(W)) u_find (
    .req    (req),
    .idx    (win_idx),
    .onehot (win_onehot),
    .none   (win_none)
  );
`endif

  // Output register. Load on accept. Drop valid when the result is consumed.
  // Hold the fields while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_none   <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_idx    <= win_idx;
      out_onehot <= win_onehot;
      out_none   <= win_none;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed bench for prio_enc_rr with N=4. Most vectors come from a table.
// The multi-cycle corner cases are written out as short sequences. The
// expected values follow the PRIO_ENC_RR_EN setting used for the RTL build.
module tb_prio_enc_rr;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] req = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_none;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] idx;
    logic [N-1:0] onehot;
    logic         none;
  } vec_t;

  vec_t tbl[16];

  prio_enc_rr #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .req        (req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_none   (out_none)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic chk_out(input string nm, input logic [W-1:0] idx,
                         input logic [N-1:0] oh, input logic none);
    chk({nm, ".valid"},  64'(out_valid),  64'(1'b1));
    chk({nm, ".idx"},    64'(out_idx),    64'(idx));
    chk({nm, ".onehot"}, 64'(out_onehot), 64'(oh));
    chk({nm, ".none"},   64'(out_none),   64'(none));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; req = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // Round-robin reference: walk p, p-1, ... with wrap and take the first set bit.
  task automatic rr_ref(input logic [N-1:0] r, input int p, output logic [W-1:0] idx,
                        output logic [N-1:0] oh, output logic none);
    idx = '0; oh = '0; none = 1'b1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p - k + N) % N;
      if (none && r[j]) begin
        idx = W'(j); oh = '0; oh[j] = 1'b1; none = 1'b0;
      end
    end
  endtask

  initial begin
    logic [W-1:0] e_idx;
    logic [N-1:0] e_oh;
    logic         e_none;
    int           ptr;
    logic [W-1:0] rr_exp[6];
    logic [N-1:0] b2b_req[4];

    // Fixed-priority expectations, worked out by hand.
    tbl[0]  = '{4'b0000, 2'd0, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0001, 2'd0, 4'b0001, 1'b0};
    tbl[2]  = '{4'b0010, 2'd1, 4'b0010, 1'b0};
    tbl[3]  = '{4'b0011, 2'd1, 4'b0010, 1'b0};
    tbl[4]  = '{4'b0100, 2'd2, 4'b0100, 1'b0};
    tbl[5]  = '{4'b0101, 2'd2, 4'b0100, 1'b0};
    tbl[6]  = '{4'b0110, 2'd2, 4'b0100, 1'b0};
    tbl[7]  = '{4'b0111, 2'd2, 4'b0100, 1'b0};
    tbl[8]  = '{4'b1000, 2'd3, 4'b1000, 1'b0};
    tbl[9]  = '{4'b1001, 2'd3, 4'b1000, 1'b0};
    tbl[10] = '{4'b1010, 2'd3, 4'b1000, 1'b0};
    tbl[11] = '{4'b1011, 2'd3, 4'b1000, 1'b0};
    tbl[12] = '{4'b1100, 2'd3, 4'b1000, 1'b0};
    tbl[13] = '{4'b1101, 2'd3, 4'b1000, 1'b0};
    tbl[14] = '{4'b1110, 2'd3, 4'b1000, 1'b0};
    tbl[15] = '{4'b1111, 2'd3, 4'b1000, 1'b0};

`ifdef PRIO_ENC_RR_EN
    rr_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
`else
    rr_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
`endif
    b2b_req = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // Reset and idle
    do_reset();
    step();
    chk("reset.valid",  64'(out_valid),  64'(0));
    chk("reset.idx",    64'(out_idx),    64'(0));
    chk("reset.onehot", 64'(out_onehot), 64'(0));
    chk("reset.none",   64'(out_none),   64'(0));
    chk("reset.ready",  64'(in_ready),   64'(1));

    // Sweep all 16 request patterns back to back with the consumer always ready
    ptr = N - 1;
    out_ready = 1'b1;
    for (int vi = 0; vi < 16; vi++) begin
      in_valid = 1'b1;
      req = tbl[vi].req;
      step();
`ifdef PRIO_ENC_RR_EN
      rr_ref(tbl[vi].req, ptr, e_idx, e_oh, e_none);
      if (!e_none) ptr = (e_idx == 0) ? N - 1 : int'(e_idx) - 1;
`else
      e_idx = tbl[vi].idx; e_oh = tbl[vi].onehot; e_none = tbl[vi].none;
`endif
      chk_out($sformatf("sweep[%0d]", vi), e_idx, e_oh, e_none);
      chk($sformatf("sweep[%0d].ready", vi), 64'(in_ready), 64'(1));
    end

    // Rotation: five accepts of 1111, then 0011 with the pointer at 2
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      req = (k < 5) ? 4'b1111 : 4'b0011;
      step();
      chk($sformatf("rr[%0d].idx", k), 64'(out_idx), 64'(rr_exp[k]));
      chk($sformatf("rr[%0d].valid", k), 64'(out_valid), 64'(1));
    end

    // Backpressure: hold the result and ignore a changed req
    do_reset();
    in_valid = 1'b1; req = 4'b0100; out_ready = 1'b0;
    step();
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("bp_hold[%0d]", k), 2'd2, 4'b0100, 1'b0);
      chk($sformatf("bp_hold[%0d].ready", k), 64'(in_ready), 64'(0));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.ready", 64'(in_ready), 64'(1));
    step();
    chk_out("bp_next", 2'd3, 4'b1000, 1'b0);
    in_valid = 1'b0;
    step();
    chk("bp_drain.valid", 64'(out_valid), 64'(0));

    // Back to back: simultaneous consume and accept, no bubbles
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      req = b2b_req[k];
      step();
      chk_out($sformatf("b2b[%0d]", k), W'(3 - k), b2b_req[k], 1'b0);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drain.valid", 64'(out_valid), 64'(0));

    // Reset mid-operation: the held result is dropped and the pointer restored
    do_reset();
    in_valid = 1'b1; req = 4'b1111; out_ready = 1'b0;
    step();
    chk_out("mid_first", 2'd3, 4'b1000, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst.valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("mid_after", 2'd3, 4'b1000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
